// File: rtl/nco_freq_meas.sv
// nco_freq_meas: counts sig_in rising edges over a 2^GATE_LOG2-clock gate and
// returns the matching NCO phase increment through a valid/ready output register.
// Params: WIDTH (estimate width), GATE_LOG2 (log2 gate length), SYNC_STAGES (>=2).
// Ports: clk, arst_n (async, active low), enable, sig_in (async), meas_ready,
//        meas_valid, phase_inc_est[WIDTH], edge_count[GATE_LOG2], overrun, lock.
// Optional: define NCO_FREQ_MEAS_LOCK_EN to build the window-to-window lock detector.
module nco_freq_meas #(
  parameter int WIDTH       = 64,
  parameter int GATE_LOG2   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 enable,
  input  logic                 sig_in,
  input  logic                 meas_ready,
  output logic                 meas_valid,
  output logic [WIDTH-1:0]     phase_inc_est,
  output logic [GATE_LOG2-1:0] edge_count,
  output logic                 overrun,
  output logic                 lock
);

  localparam int SW = $clog2(SYNC_STAGES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] GATE   = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise;

  logic [1:0]             state;
  logic [SW-1:0]          settle_cnt;
  logic [GATE_LOG2-1:0]   gate_cnt;
  logic [GATE_LOG2-1:0]   edge_cnt;
  logic [GATE_LOG2-1:0]   cnt_next;
  logic                   gate_last;
  logic                   load;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Count including a rise in the current cycle, saturating at all-ones.
  assign cnt_next = (rise && (edge_cnt != '1))
                  ? edge_cnt + GATE_LOG2'(1)
                  : edge_cnt;

  assign gate_last = (state == GATE) && (gate_cnt == '1);
  assign load      = enable && gate_last;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
    end else if (!enable) begin
      state      <= IDLE;
      settle_cnt <= '0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          state      <= SETTLE;
          settle_cnt <= '0;
        end
        // Rises are ignored here so pre-enable synchronizer content is flushed.
        (state == SETTLE): begin
          if (settle_cnt == SW'(SYNC_STAGES)) begin
            state    <= GATE;
            gate_cnt <= '0;
            edge_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        // Gate counter wraps to 0 after the last cycle: windows are back to back.
        (state == GATE): begin
          gate_cnt <= gate_cnt + GATE_LOG2'(1);
          edge_cnt <= gate_last ? '0 : cnt_next;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meas_valid    <= 1'b0;
      phase_inc_est <= '0;
      edge_count    <= '0;
      overrun       <= 1'b0;
    end else begin
      overrun <= load & meas_valid & ~meas_ready;
      if (load) begin
        meas_valid    <= 1'b1;
        edge_count    <= cnt_next;
        phase_inc_est <= {cnt_next, {(WIDTH-GATE_LOG2){1'b0}}};
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end
    end
  end

`ifdef NCO_FREQ_MEAS_LOCK_EN
  logic [GATE_LOG2-1:0] prev_cnt;
  logic [GATE_LOG2-1:0] cnt_diff;
  logic                 prev_ok;

  assign cnt_diff = (cnt_next >= prev_cnt)
                  ? cnt_next - prev_cnt
                  : prev_cnt - cnt_next;

  // prev_ok marks that prev_cnt came from a complete window of this run.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      lock     <= 1'b0;
      prev_ok  <= 1'b0;
      prev_cnt <= '0;
    end else if (!enable) begin
      lock    <= 1'b0;
      prev_ok <= 1'b0;
    end else if (load) begin
      lock     <= prev_ok && (cnt_diff <= GATE_LOG2'(1));
      prev_cnt <= cnt_next;
      prev_ok  <= 1'b1;
    end
  end
`else
  assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_nco_freq_meas.sv
// tb_nco_freq_meas: random and directed stimulus for nco_freq_meas
// (WIDTH=32, GATE_LOG2=8, SYNC_STAGES=2) against a window-level edge-count model.
module tb_nco_freq_meas;

  localparam int W = 32;
  localparam int G = 8;
  localparam int S = 2;
  localparam int WIN = 1 << G;

  logic         clk;
  logic         arst_n;
  logic         enable;
  logic         sig_in;
  logic         meas_ready;
  logic         meas_valid;
  logic [W-1:0] phase_inc_est;
  logic [G-1:0] edge_count;
  logic         overrun;
  logic         lock;

  nco_freq_meas #(
    .WIDTH(W),
    .GATE_LOG2(G),
    .SYNC_STAGES(S)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .enable(enable),
    .sig_in(sig_in),
    .meas_ready(meas_ready),
    .meas_valid(meas_valid),
    .phase_inc_est(phase_inc_est),
    .edge_count(edge_count),
    .overrun(overrun),
    .lock(lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int n = 0;
  bit sbuf [0:32767];

  int smode = 0;
  int rmode = 0;
  int per = 16;
  int ph = 0;

  bit run = 0;
  int e1 = 0;
  bit ev = 0;
  bit eov = 0;
  bit elock = 0;
  bit hp = 0;
  int ecnt = 0;
  int prev = 0;
  bit last_load = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", tag, got, exp, n);
    end
  endtask

  // Rising edges of the sampled input that land inside the window ending at
  // edge 'last', allowing for the S+1 clock input-to-count latency.
  function automatic int win_count(input int last);
    int k;
    k = 0;
    for (int c = last - WIN + 1; c <= last; c++)
      if (!sbuf[c-S-1] && sbuf[c-S]) k++;
    return k;
  endfunction

  task automatic model_edge(input bit e, input bit r);
    bit ld;
    int cnt;
    int d;
    ld = 0;
    if (!e) begin
      run   = 0;
      hp    = 0;
      elock = 0;
    end else if (!run) begin
      run = 1;
      e1  = n;
    end else if (n >= e1 + S + 1 + WIN && ((n - e1 - S - 1) % WIN) == 0) begin
      ld = 1;
    end
    if (ld) begin
      cnt  = win_count(n);
      eov  = ev && !r;
      ev   = 1;
      ecnt = cnt;
`ifdef NCO_FREQ_MEAS_LOCK_EN
      d     = (cnt > prev) ? cnt - prev : prev - cnt;
      elock = hp && (d <= 1);
      prev  = cnt;
      hp    = 1;
`else
      d = 0;
`endif
    end else begin
      eov = 0;
      if (ev && r) ev = 0;
    end
    last_load = ld;
  endtask

  task automatic tick();
    bit e_s;
    bit r_s;
    if (smode == 1) begin
      sig_in = ((ph % per) < (per / 2));
      ph++;
    end else if (smode == 2) begin
      sig_in = 1'($urandom_range(0, 1));
    end
    if (rmode != 0) meas_ready = 1'($urandom_range(0, 1));
    sbuf[n+1] = sig_in;
    e_s = enable;
    r_s = meas_ready;
    @(posedge clk);
    n++;
    model_edge(e_s, r_s);
    #1;
    chk("valid", 64'(meas_valid), 64'(ev));
    chk("overrun", 64'(overrun), 64'(eov));
    chk("lock", 64'(lock), 64'(elock));
    if (ev) begin
      chk("count", 64'(edge_count), 64'(ecnt));
      chk("phase", 64'(phase_inc_est), 64'(ecnt) * 64'h0100_0000);
    end
  endtask

  task automatic run_n(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic reset_pulse();
    arst_n = 1'b0;
    enable = 1'b0;
    #1;
    run = 0; ev = 0; eov = 0; elock = 0; hp = 0; ecnt = 0; last_load = 0;
    chk("rst_valid", 64'(meas_valid), 64'd0);
    chk("rst_count", 64'(edge_count), 64'd0);
    chk("rst_phase", 64'(phase_inc_est), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_lock", 64'(lock), 64'd0);
    for (int i = 0; i < 2; i++) begin
      sbuf[n+1] = sig_in;
      @(posedge clk);
      n++;
    end
    #1;
    arst_n = 1'b1;
  endtask

  task automatic wait_load();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!last_load && k < 3 * WIN);
    if (!last_load) chk("load_timeout", 64'd0, 64'd1);
  endtask

  task automatic measure_lat(input string tag);
    int k;
    enable     = 1'b0;
    meas_ready = 1'b1;
    rmode      = 0;
    tick();
    tick();
    enable = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!meas_valid && k < 400);
    chk(tag, 64'(k), 64'd260);
  endtask

  initial begin
    arst_n     = 1'b0;
    enable     = 1'b0;
    sig_in     = 1'b0;
    meas_ready = 1'b0;
    reset_pulse();
    run_n(5);

    smode = 1;
    per   = 16;
    measure_lat("p16_latency");
    chk("p16_cnt", 64'(edge_count), 64'd16);
    chk("p16_phase", 64'(phase_inc_est), 64'h1000_0000);
    run_n(600);

    per = 2;
    run_n(600);
    chk("tog_cnt", 64'(edge_count), 64'd128);
    chk("tog_phase", 64'(phase_inc_est), 64'h8000_0000);

    smode  = 0;
    sig_in = 1'b0;
    run_n(600);
    chk("low_cnt", 64'(edge_count), 64'd0);
    sig_in = 1'b1;
    run_n(600);
    chk("high_cnt", 64'(edge_count), 64'd0);

    smode = 1;
    per   = 16;
    meas_ready = 1'b1;
    wait_load();
    tick();
    meas_ready = 1'b0;
    wait_load();
    chk("ovr_first", 64'(overrun), 64'd0);
    wait_load();
    chk("ovr_second", 64'(overrun), 64'd1);
    tick();
    chk("ovr_pulse_end", 64'(overrun), 64'd0);
    chk("ovr_held", 64'(meas_valid), 64'd1);
    meas_ready = 1'b1;
    tick();
    chk("ovr_accept", 64'(meas_valid), 64'd0);
    meas_ready = 1'b0;

    wait_load();
    run_n(WIN - 1);
    meas_ready = 1'b1;
    tick();
    chk("same_cyc_load", 64'(last_load), 64'd1);
    chk("same_cyc_valid", 64'(meas_valid), 64'd1);
    chk("same_cyc_ovr", 64'(overrun), 64'd0);
    chk("same_cyc_cnt", 64'(edge_count), 64'd16);

    wait_load();
    run_n(100);
    reset_pulse();
    run_n(300);
    chk("rst_mid_novalid", 64'(meas_valid), 64'd0);
    measure_lat("rst_restart_latency");

    wait_load();
    tick();
    run_n(99);
    enable = 1'b0;
    run_n(300);
    chk("drop_novalid", 64'(meas_valid), 64'd0);
    measure_lat("drop_restart_latency");

    rmode = 1;
    for (int w = 0; w < 12; w++) begin
      if ($urandom_range(0, 2) == 0) begin
        smode = 2;
      end else begin
        smode = 1;
        per   = 2 * int'($urandom_range(1, 20));
      end
      run_n(WIN + int'($urandom_range(0, 40)));
    end

    smode = 1;
    per   = 16;
    measure_lat("lock_latency");
    chk("lock_first", 64'(lock), 64'd0);
    wait_load();
`ifdef NCO_FREQ_MEAS_LOCK_EN
    chk("lock_steady", 64'(lock), 64'd1);
`else
    chk("lock_off_steady", 64'(lock), 64'd0);
`endif
    per = 8;
    wait_load();
    chk("lock_switch", 64'(lock), 64'd0);
    wait_load();
    wait_load();
`ifdef NCO_FREQ_MEAS_LOCK_EN
    chk("lock_relock", 64'(lock), 64'd1);
`else
    chk("lock_off_relock", 64'(lock), 64'd0);
`endif
    enable = 1'b0;
    tick();
    chk("lock_idle", 64'(lock), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
